// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field layout, integer
// range limits, exponent landmarks used by the float-to-int path, and the
// operand class used between pipeline stages.
//
// Contents:
//   FP_BIAS, EXP_W, MAN_W          float format constants
//   INT32_MAX, INT32_MIN           signed 32-bit saturation values
//   EXP_* landmarks                biased exponents for 0.5, 1.0, 2^23, 2^31
//   fp32_t                         packed {s, e, m}
//   ftoi_cls_t                     CLS_ZERO / CLS_NORM / CLS_SAT
//   ftoi_classify()                exponent -> class for a rounding mode
package fpu_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    // Biased exponents of 0.5, 1.0, 2^23 (integer LSB aligned with the
    // mantissa LSB) and 2^31 (first magnitude that no longer fits).
    localparam logic [EXP_W-1:0] EXP_HALF    = 8'(FP_BIAS - 1);
    localparam logic [EXP_W-1:0] EXP_ONE     = 8'(FP_BIAS);
    localparam logic [EXP_W-1:0] EXP_PIVOT   = 8'(FP_BIAS + MAN_W);
    localparam logic [EXP_W-1:0] EXP_SAT     = 8'(FP_BIAS + 31);
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp32_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_SAT
    } ftoi_cls_t;

    // Anything below 0.5 (nearest) or below 1.0 (truncate) produces 0,
    // which also covers denormals and signed zero. Magnitudes of 2^31 and
    // above, infinities and NaNs all saturate.
    function automatic ftoi_cls_t ftoi_classify(input logic [EXP_W-1:0] e,
                                                input logic trunc);
        ftoi_cls_t cls;
        if (e >= EXP_SAT)
            cls = CLS_SAT;
        else if (e < (trunc ? EXP_ONE : EXP_HALF))
            cls = CLS_ZERO;
        else
            cls = CLS_NORM;
        return cls;
    endfunction

endpackage

// File: rtl/ftoi_shift_round.sv
// Combinational magnitude extraction for the float-to-int converter.
// Aligns the 24-bit significand to the integer binary point and applies
// round-to-nearest (ties away from zero) unless TRUNC is set.
//
// Only meaningful for NORM operands (biased exponent 126..157); other
// exponents produce an unspecified value that the caller discards.
//
// Ports:
//   sig  in   24  significand {1, m}
//   e    in   8   biased exponent
//   a    out  32  rounded magnitude, at most 2^31 - 128
module ftoi_shift_round
    import fpu_pkg::*;
#(
    parameter bit TRUNC = 1'b0
) (
    input  logic [23:0] sig,
    input  logic [7:0]  e,
    output logic [31:0] a
);

    logic [31:0] wide;
    logic [31:0] mag;
    logic [31:0] half_vec;
    logic [2:0]  lsh;
    logic [4:0]  rsh;
    logic        rbit;

    always_comb begin
        wide     = {8'd0, sig};
        lsh      = 3'(e - EXP_PIVOT);
        rsh      = 5'(EXP_PIVOT - e);
        mag      = '0;
        half_vec = '0;
        rbit     = 1'b0;
        if (e >= EXP_PIVOT) begin
            // Integer already; left shift of at most 7 keeps it below 2^31.
            mag = wide << lsh;
        end else begin
            // The bit just below the binary point is the 2^-1 weight. At
            // e = 126 the shift is 24, so it is sig[23] and mag is 0.
            mag      = wide >> rsh;
            half_vec = wide >> (rsh - 5'd1);
            rbit     = half_vec[0];
        end
        a = mag + {31'd0, (TRUNC ? 1'b0 : rbit)};
    end

endmodule

// File: rtl/ftoi_pipe.sv
// Three-stage IEEE-754 single-precision to signed 32-bit integer converter.
//   Stage 1: unpack and classify the operand.
//   Stage 2: align and round the magnitude (ftoi_shift_round).
//   Stage 3: apply sign and saturation, register result and overflow flag.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready does not depend on in_valid; out_valid does not
// depend on out_ready. Once out_valid is high, y/ovf stay stable until the
// output transfer. The whole pipe advances together when the output slot is
// empty or being drained (en = !out_valid | out_ready); otherwise every
// register holds. Empty slots travel as bubbles and are not squeezed out.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset, drops in-flight data
//   x          in   32  float operand {s, e, m}
//   in_valid   in   1   x is valid
//   in_ready   out  1   pipe accepts x this cycle
//   y          out  32  signed integer result
//   ovf        out  1   result saturated (overflow, infinity or NaN)
//   out_valid  out  1   y/ovf valid
//   out_ready  in   1   consumer takes y this cycle
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter bit TRUNC = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    fp32_t     x_f;
    logic      en;

    // Stage 1 registers.
    logic      v1;
    logic      s1;
    logic [7:0]  e1;
    logic [23:0] sig1;
    ftoi_cls_t cls1;
    logic      nan1;
    logic      min1;

    // Stage 2 registers.
    logic      v2;
    logic      s2;
    ftoi_cls_t cls2;
    logic      nan2;
    logic      min2;
    logic [31:0] a2;

    // Combinational helpers.
    ftoi_cls_t cls_in;
    logic      nan_in;
    logic      min_in;
    logic [31:0] a_rnd;
    logic [31:0] y_next;
    logic      ovf_next;

    assign x_f      = x;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        cls_in = ftoi_classify(x_f.e, TRUNC);
        nan_in = (x_f.e == EXP_SPECIAL) && (x_f.m != '0);
        // -2^31 is the one SAT-class value that is exactly representable.
        min_in = x_f.s && (x_f.e == EXP_SAT) && (x_f.m == '0);
    end

    ftoi_shift_round #(
        .TRUNC (TRUNC)
    ) u_shift_round (
        .sig (sig1),
        .e   (e1),
        .a   (a_rnd)
    );

    always_comb begin
        y_next   = '0;
        ovf_next = 1'b0;
        case (cls2)
            CLS_NORM: begin
                y_next = s2 ? (32'd0 - a2) : a2;
            end
            CLS_SAT: begin
                if (min2) begin
                    y_next = INT32_MIN;
                end else if (nan2) begin
                    y_next   = INT32_MAX;
                    ovf_next = 1'b1;
                end else begin
                    y_next   = s2 ? INT32_MIN : INT32_MAX;
                    ovf_next = 1'b1;
                end
            end
            default: begin
                y_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            s1        <= 1'b0;
            e1        <= '0;
            sig1      <= '0;
            cls1      <= CLS_ZERO;
            nan1      <= 1'b0;
            min1      <= 1'b0;
            v2        <= 1'b0;
            s2        <= 1'b0;
            cls2      <= CLS_ZERO;
            nan2      <= 1'b0;
            min2      <= 1'b0;
            a2        <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            s1        <= x_f.s;
            e1        <= x_f.e;
            sig1      <= {1'b1, x_f.m};
            cls1      <= cls_in;
            nan1      <= nan_in;
            min1      <= min_in;

            v2        <= v1;
            s2        <= s1;
            cls2      <= cls1;
            nan2      <= nan1;
            min2      <= min1;
            a2        <= a_rnd;

            out_valid <= v2;
            y         <= y_next;
            ovf       <= ovf_next;
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: two instances (nearest and truncate) share stimulus
// and out_ready. Expected {ovf, y} pairs are queued at input acceptance and
// popped by a monitor on each output transfer.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready0, out_valid0, ovf0;
  logic [31:0] y0;
  logic        in_ready1, out_valid1, ovf1;
  logic [31:0] y1;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ftoi_pipe #(.TRUNC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready0),
    .y(y0), .ovf(ovf0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  ftoi_pipe #(.TRUNC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready1),
    .y(y1), .ovf(ovf1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact value of the float, rounded by plain integer
  // arithmetic, then clamped to the int32 range.
  function automatic logic [32:0] ref_conv(input logic [31:0] v, input bit trunc);
    int     e;
    int     sh;
    longint sig;
    longint r;
    longint val;
    e   = int'(v[30:23]);
    sig = longint'({1'b1, v[22:0]});
    r   = 0;
    if (e == 255 && v[22:0] != 23'd0) return {1'b1, 32'h7FFF_FFFF};
    if (e == 255) begin
      r = longint'(64'd1) << 40;
    end else if (e == 0) begin
      r = 0;
    end else if (e >= 150) begin
      if (e - 150 > 16) r = longint'(64'd1) << 40;
      else r = sig << (e - 150);
    end else begin
      sh = 150 - e;
      if (sh > 25) r = 0;
      else if (trunc) r = sig >> sh;
      else r = (sig + (longint'(64'd1) << (sh - 1))) >> sh;
    end
    val = v[31] ? -r : r;
    if (val > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (val < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, val[31:0]};
  endfunction

  // Monitor: result order/value, spurious outputs, hold-while-stalled.
  logic        st0 = 1'b0, st1 = 1'b0;
  logic [32:0] hold0, hold1;

  always @(negedge clk) begin
    if (rst) begin
      st0 = 1'b0;
      st1 = 1'b0;
    end else begin
      if (st0) begin
        chk("stall_valid0", {32'd0, out_valid0}, 33'd1);
        chk("stall_hold0", {ovf0, y0}, hold0);
      end
      if (st1) begin
        chk("stall_valid1", {32'd0, out_valid1}, 33'd1);
        chk("stall_hold1", {ovf1, y1}, hold1);
      end
      if (out_valid0 && out_ready) begin
        if (exp_q0.size() == 0) chk("spurious0", {ovf0, y0}, 33'h1_DEAD_BEEF);
        else chk("result0", {ovf0, y0}, exp_q0.pop_front());
      end
      if (out_valid1 && out_ready) begin
        if (exp_q1.size() == 0) chk("spurious1", {ovf1, y1}, 33'h1_DEAD_BEEF);
        else chk("result1", {ovf1, y1}, exp_q1.pop_front());
      end
      st0   = out_valid0 && !out_ready;
      st1   = out_valid1 && !out_ready;
      hold0 = {ovf0, y0};
      hold1 = {ovf1, y1};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] v, input logic [32:0] e0, input logic [32:0] e1);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    x = v;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout: observed not accepted expected accepted for %h", v);
    end
    if (acc) begin
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
    end
  endtask

  task automatic send_val(input logic [31:0] v);
    send(v, ref_conv(v, 1'b0), ref_conv(v, 1'b1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (exp_q0.size() == 0 && exp_q1.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  // Single item into an empty pipe: out_valid must rise on the third edge
  // counting the accepting edge, and last exactly one cycle.
  task automatic latency_probe(input string tag, input logic [31:0] v);
    int n;
    send_val(v);
    n = 1;
    while (!out_valid0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 33'(n), 33'd3);
    @(posedge clk);
    #1;
    chk("single_pulse", {32'd0, out_valid0}, 33'd0);
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] v;
    logic [7:0]  ex;
    int          k;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: ex = v[30:23];
      1, 2: ex = 8'($urandom_range(118, 162));
      default: begin
        k = $urandom_range(0, 5);
        ex = (k == 0) ? 8'd0 : (k == 1) ? 8'd255 : (k == 2) ? 8'd126 :
             (k == 3) ? 8'd127 : (k == 4) ? 8'd157 : 8'd158;
        if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
      end
    endcase
    v[30:23] = ex;
    return v;
  endfunction

  // Directed vectors: x, expected {ovf,y} nearest, expected {ovf,y} truncate.
  localparam int NDIR = 16;
  logic [31:0] dir_x  [NDIR] = '{32'h3F80_0000, 32'h4020_0000, 32'hC020_0000, 32'h3F00_0000,
                                 32'h3ECC_CCCD, 32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000,
                                 32'hCF00_0001, 32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000,
                                 32'h0000_0001, 32'hBF00_0000, 32'h7F80_0000, 32'hFF80_0001};
  logic [32:0] dir_e0 [NDIR] = '{33'h0_0000_0001, 33'h0_0000_0003, 33'h0_FFFF_FFFD, 33'h0_0000_0001,
                                 33'h0_0000_0000, 33'h0_7FFF_FF80, 33'h1_7FFF_FFFF, 33'h0_8000_0000,
                                 33'h1_8000_0000, 33'h1_7FFF_FFFF, 33'h1_8000_0000, 33'h0_0000_0000,
                                 33'h0_0000_0000, 33'h0_FFFF_FFFF, 33'h1_7FFF_FFFF, 33'h1_7FFF_FFFF};
  logic [32:0] dir_e1 [NDIR] = '{33'h0_0000_0001, 33'h0_0000_0002, 33'h0_FFFF_FFFE, 33'h0_0000_0000,
                                 33'h0_0000_0000, 33'h0_7FFF_FF80, 33'h1_7FFF_FFFF, 33'h0_8000_0000,
                                 33'h1_8000_0000, 33'h1_7FFF_FFFF, 33'h1_8000_0000, 33'h0_0000_0000,
                                 33'h0_0000_0000, 33'h0_0000_0000, 33'h1_7FFF_FFFF, 33'h1_7FFF_FFFF};

  bit rnd_done;

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    x         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_out_valid0", {32'd0, out_valid0}, 33'd0);
    chk("rst_out_valid1", {32'd0, out_valid1}, 33'd0);
    chk("rst_y_ovf0", {ovf0, y0}, 33'd0);
    chk("rst_y_ovf1", {ovf1, y1}, 33'd0);
    chk("rst_in_ready0", {32'd0, in_ready0}, 33'd1);
    chk("rst_in_ready1", {32'd0, in_ready1}, 33'd1);

    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Latency of a lone item.
    latency_probe("latency", 32'h4020_0000);
    drain();

    // Directed table, back to back.
    for (int i = 0; i < NDIR; i++) send(dir_x[i], dir_e0[i], dir_e1[i]);
    drain();

    // Backpressure: 6 back-to-back items, out_ready low for 4 cycles.
    fork
      begin
        for (int i = 0; i < 6; i++) send_val(32'h4000_0000 + 32'(i) * 32'h0020_0000);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_in_ready", {32'd0, in_ready0}, 33'd0);
          chk("bp_out_valid", {32'd0, out_valid0}, 33'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three items in flight.
    out_ready = 1'b0;
    send_val(32'h3F80_0000);
    send_val(32'h4040_0000);
    send_val(32'hC0A0_0000);
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_flush_valid0", {32'd0, out_valid0}, 33'd0);
    chk("rst_flush_valid1", {32'd0, out_valid1}, 33'd0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    latency_probe("latency_after_rst", 32'h3F80_0000);
    drain();

    // Random operands under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_val(rand_float());
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    repeat (4) @(posedge clk);
    #1;
    chk("leftover0", 33'(exp_q0.size()), 33'd0);
    chk("leftover1", 33'(exp_q1.size()), 33'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
